result_uart_tx: RTL and testbench
=================================

RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 SHALL have parameter NB_DATA, default 8: width of the data word transmitted per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 10417: clock cycles per serial bit (100 MHz / 9600 baud); legal range is 2 or more.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port i_data, input, NB_DATA bits: the word to send, normally the ALU o_result.
REQ-006 SHALL have port i_tx_start, input, 1 bit: request to start a frame; level-sampled.
REQ-007 SHALL have port o_tx, output, 1 bit: serial line; idles high.
REQ-008 SHALL have port o_tx_busy, output, 1 bit: high while a frame is in progress.
REQ-009 SHALL have port o_tx_done, output, 1 bit: one-cycle pulse when a frame completes.

Function
REQ-010 SHALL implement the state machine IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, where PARITY exists only per REQ-022.
REQ-011 SHALL, in IDLE, accept i_tx_start=1 by latching i_data into a shift register in that same cycle and entering START on the next cycle.
REQ-012 SHALL ignore i_tx_start while o_tx_busy=1; the latched word SHALL be immune to i_data changes after acceptance.
REQ-013 SHALL hold each bit on o_tx for exactly CLKS_PER_BIT cycles, timed by a bit-cycle counter that restarts at every bit boundary.
REQ-014 SHALL transmit, in order: a start bit of 0, then NB_DATA data bits LSB first, then [a parity bit], then a stop bit of 1.
REQ-015 SHALL count data bits with a counter of width clog2(NB_DATA); DATA exits after bit NB_DATA-1 with no wrap into a further bit.
REQ-016 SHALL drive o_tx_busy=1 in START, DATA, PARITY and STOP, and 0 in IDLE; o_tx and o_tx_busy are registered outputs.
REQ-017 SHALL pulse o_tx_done=1 for exactly one cycle: the first IDLE cycle after STOP completes.
REQ-018 SHALL accept an i_tx_start that is high in the o_tx_done cycle, giving back-to-back frames with no extra idle bit.
REQ-019 SHALL make the first o_tx falling edge occur 1 cycle after acceptance; frame length is (NB_DATA+2)*CLKS_PER_BIT cycles, or +CLKS_PER_BIT with parity.

Reset
REQ-020 SHALL, while i_reset=1, force state=IDLE, o_tx=1, o_tx_busy=0, o_tx_done=0, and clear all counters and the shift register.
REQ-021 SHALL abort any in-progress frame when i_reset asserts mid-frame: o_tx=1 on the next cycle, and no o_tx_done is produced for the aborted frame.

Configuration
REQ-022 SHALL compile in the PARITY state when macro RESULT_UART_TX_PARITY_EN is defined: one even-parity bit (XOR of the data bits), lasting CLKS_PER_BIT cycles, between the last data bit and the stop bit.
REQ-023 SHALL, when RESULT_UART_TX_PARITY_EN is undefined, have no PARITY state and no parity logic; the frame is 8N1-style.

Structure
REQ-024 SHALL take the following from a shared package: the state encoding type (IDLE, START, DATA, PARITY, STOP) and the default constants for NB_DATA and CLKS_PER_BIT, shared with the ALU/interface tops.
REQ-025 SHALL place the bit-cycle counter in sub-module tx_bit_timer, which has inputs clk, i_reset and i_restart and output o_bit_end, where o_bit_end pulses at count CLKS_PER_BIT-1.
REQ-026 SHALL be instantiable in the ALU top with i_data driven from o_result and i_tx_start driven from a debounced button.

Verification (NB_DATA=8, CLKS_PER_BIT=4)
REQ-027 SHALL cover: i_tx_start for 1 cycle with i_data=8'hA5 -> o_tx=0 for 4 cycles, then bits 1,0,1,0,0,1,0,1, each for 4 cycles, then 1 for 4 cycles; o_tx_done pulses at cycle 41 after acceptance.
REQ-028 SHALL cover: i_data changed to 8'h00 and i_tx_start re-pulsed mid-frame -> the frame still carries 8'hA5 and no second frame starts.
REQ-029 SHALL cover: i_tx_start held high continuously with i_data=8'h3C -> back-to-back frames, the second start bit beginning immediately after the first stop bit, and o_tx_done once per frame.
REQ-030 SHALL cover: i_reset pulsed during data bit 3 -> o_tx=1 and o_tx_busy=0 on the next cycle, no o_tx_done, and a subsequent frame sent correctly.
REQ-031 SHALL cover: with RESULT_UART_TX_PARITY_EN, i_data=8'h07 -> a parity bit of 1 between the MSB and the stop bit; the frame is 44 cycles long.
REQ-032 SHALL cover: i_data=8'hFF with no start request for 100 cycles -> o_tx stays 1 and o_tx_busy stays 0.

Source files
------------

// File: rtl/result_uart_tx_pkg.sv
// Shared types and defaults for the result UART transmitter and the ALU/interface tops.
// Optional macro RESULT_UART_TX_PARITY_EN adds the PARITY state to the encoding.
package result_uart_tx_pkg;

  localparam int NB_DATA_DEF      = 8;
  localparam int CLKS_PER_BIT_DEF = 10417;  // 100 MHz / 9600 baud

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef RESULT_UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/result_uart_tx_bit_timer.sv
// Bit-period timer: free-running counter that wraps every CLKS_PER_BIT cycles,
// realigned to zero by i_restart when a frame is accepted.
module tx_bit_timer
  import result_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_restart,
  output logic o_bit_end
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign o_bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (i_restart || o_bit_end) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/result_uart_tx.sv
// UART transmitter for the ALU result: start bit, NB_DATA bits LSB first, stop bit.
// Define RESULT_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module result_uart_tx
  import result_uart_tx_pkg::*;
#(
  parameter int NB_DATA      = NB_DATA_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_tx_start,
  output logic               o_tx,
  output logic               o_tx_busy,
  output logic               o_tx_done
);

  localparam int BCW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  tx_state_e          state_q, state_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               accept;
  logic               bit_end;
`ifdef RESULT_UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  assign accept = (state_q == IDLE) && i_tx_start;

  tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk       (clk),
    .i_reset   (i_reset),
    .i_restart (accept),
    .o_bit_end (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
`ifdef RESULT_UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: if (i_tx_start) begin
        state_d   = START;
        shift_d   = i_data;
        bit_cnt_d = '0;
`ifdef RESULT_UART_TX_PARITY_EN
        parity_d  = ^i_data;
`endif
      end
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        if (bit_cnt_q == BCW'(NB_DATA - 1)) begin
`ifdef RESULT_UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + BCW'(1);
          shift_d   = shift_q >> 1;
        end
      end
`ifdef RESULT_UART_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: if (bit_end) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Line and busy are registered, so they are decoded from the next state.
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef RESULT_UART_TX_PARITY_EN
      PARITY:  tx_d = parity_q;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef RESULT_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef RESULT_UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign o_tx      = tx_q;
  assign o_tx_busy = busy_q;
  assign o_tx_done = done_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Scoreboard bench for result_uart_tx (NB_DATA=8, CLKS_PER_BIT=4); frames are
// decoded from o_tx by a monitor and compared against queued expectations.
module tb_result_uart_tx;

  localparam int CPB = 4;
`ifdef RESULT_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  typedef struct {
    logic [7:0] data;
    int         start_cyc;
    bit         abort;
  } exp_t;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic       i_tx_start = 1'b0;
  logic       o_tx, o_tx_busy, o_tx_done;

  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];

  result_uart_tx #(.NB_DATA(8), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .i_reset    (i_reset),
    .i_data     (i_data),
    .i_tx_start (i_tx_start),
    .o_tx       (o_tx),
    .o_tx_busy  (o_tx_busy),
    .o_tx_done  (o_tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (o_tx_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] d);
    logic [NBITS-1:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
`ifdef RESULT_UART_TX_PARITY_EN
    f[9] = ^d;
`endif
    f[NBITS-1] = 1'b1;
    return f;
  endfunction

  task automatic wait_idle;
    int n = 0;
    while (o_tx_busy !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    chk("idle_timeout", {31'd0, o_tx_busy}, 32'd0);
  endtask

  // Monitor: decode each frame cycle by cycle and check it against the queue.
  initial begin
    exp_t             e;
    logic [NBITS-1:0] bits;
    bit               aborted;
    forever begin
      @(negedge clk);
      if (i_reset === 1'b0 && o_tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame_start", {31'd0, o_tx}, 32'd1);
          wait (o_tx_busy !== 1'b1);
        end else begin
          e = exp_q.pop_front();
          chk("start_cycle", cyc, e.start_cyc);
          bits = frame_bits(e.data);
          aborted = 1'b0;
          for (int b = 0; b < NBITS && !aborted; b++) begin
            for (int c = 0; c < CPB && !aborted; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (i_reset === 1'b1) aborted = 1'b1;
              else begin
                chk($sformatf("tx_%02h_bit%0d", e.data, b), {31'd0, o_tx}, {31'd0, bits[b]});
                if (c == 0) chk("busy_in_frame", {31'd0, o_tx_busy}, 32'd1);
              end
            end
          end
          if (!aborted) begin
            @(negedge clk);
            chk("done_pulse", {31'd0, o_tx_done}, 32'd1);
            chk("busy_at_done", {31'd0, o_tx_busy}, 32'd0);
          end
          chk("abort_seen", {31'd0, aborted}, {31'd0, e.abort});
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    total++;
    $display("FAIL watchdog: reached cycle %0d, limit 20000", cyc);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    int k, d0, bad;
    repeat (3) tick();
    chk("rst_tx", {31'd0, o_tx}, 32'd1);
    chk("rst_busy", {31'd0, o_tx_busy}, 32'd0);
    chk("rst_done", {31'd0, o_tx_done}, 32'd0);
    i_reset = 1'b0;
    repeat (2) tick();

    // Single frame 0xA5; then a mid-frame data change and re-pulse that must be ignored.
    i_data = 8'hA5; i_tx_start = 1'b1;
    exp_q.push_back('{8'hA5, cyc + 1, 1'b0});
    tick();
    i_tx_start = 1'b0;
    repeat (10) tick();
    i_data = 8'h00; i_tx_start = 1'b1;
    tick();
    i_tx_start = 1'b0;
    wait_idle();
    repeat (20) tick();

    // Start held high: two back-to-back frames, the second accepted in the done cycle.
    i_data = 8'h3C; i_tx_start = 1'b1;
    k = cyc;
    exp_q.push_back('{8'h3C, k + 1, 1'b0});
    exp_q.push_back('{8'h3C, k + 2 + NBITS * CPB, 1'b0});
    repeat (NBITS * CPB + 10) tick();
    i_tx_start = 1'b0;
    wait_idle();
    repeat (10) tick();

    // Reset during data bit 3 aborts the frame with no done pulse.
    i_data = 8'h5A; i_tx_start = 1'b1;
    k = cyc;
    exp_q.push_back('{8'h5A, k + 1, 1'b1});
    tick();
    i_tx_start = 1'b0;
    while (cyc < k + 18) tick();
    i_reset = 1'b1;
    d0 = done_cnt;
    tick();
    chk("abort_tx", {31'd0, o_tx}, 32'd1);
    chk("abort_busy", {31'd0, o_tx_busy}, 32'd0);
    i_reset = 1'b0;
    repeat (60) tick();
    chk("abort_no_done", done_cnt, d0);

    // Frame after the abort, then a frame whose parity bit (if built in) is 1.
    i_data = 8'hC3; i_tx_start = 1'b1;
    exp_q.push_back('{8'hC3, cyc + 1, 1'b0});
    tick();
    i_tx_start = 1'b0;
    wait_idle();
    repeat (5) tick();
    i_data = 8'h07; i_tx_start = 1'b1;
    exp_q.push_back('{8'h07, cyc + 1, 1'b0});
    tick();
    i_tx_start = 1'b0;
    wait_idle();
    repeat (5) tick();

    // No request: line stays idle regardless of i_data.
    i_data = 8'hFF;
    bad = 0;
    repeat (100) begin
      tick();
      if (o_tx !== 1'b1 || o_tx_busy !== 1'b0) bad++;
    end
    chk("idle_hold_bad_cycles", bad, 0);

    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("done_count", done_cnt, 5);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
